// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared types and helpers for the UART receive path.
//   rx_state_e : receiver FSM states (IDLE, START, DATA, PARITY, STOP)
//   cnt_width  : width of a counter that must hold the values 0..n-1
// -----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

  // Width of a counter holding 0..n-1. Never returns less than 1 bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_bit_sync.sv
// -----------------------------------------------------------------------------
// uart_bit_sync
// Two-flop synchronizer for a single asynchronous input. The output lags the
// input by two clk edges. The reset value is a parameter so the cell can
// synchronize idle-high lines (UART rx) as well as idle-low ones.
// Ports:
//   clk      in  system clock
//   reset_n  in  asynchronous reset, active-low
//   i_async  in  asynchronous input
//   o_sync   out synchronized copy of i_async
// -----------------------------------------------------------------------------
module uart_bit_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_async,
  output logic o_sync
);

  logic r_meta;
  logic r_sync;

  // NOTE: sequential state uses non-blocking assignments so that r_sync
  // captures the old r_meta; a blocking assignment would collapse the chain
  // into a single flop and defeat the synchronizer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/uart_rx_oversampled.sv
// -----------------------------------------------------------------------------
// uart_rx_oversampled
// UART receiver driven by a 16x (SAMPLE x) oversampling enable pulse. Recovers
// LSB-first frames from the asynchronous rx line and presents each byte in a
// one-entry valid/ready holding register with frame/overrun/parity status.
//
// Build option: define UART_RX_PARITY_EN to receive a parity bit after the
// data bits (sense chosen by PARITY_ODD). Without it, frames are
// start + DATA_BITS + stop and parity_err is tied to 0.
//
// Parameters:
//   DATA_BITS   data bits per frame (5..8)
//   SAMPLE      sample_tick pulses per bit period (even, >= 8)
//   PARITY_ODD  0 = even parity, 1 = odd parity (parity build only)
// Ports:
//   clk          in  system clock
//   reset_n      in  asynchronous reset, active-low
//   sample_tick  in  1-clk enable pulse at SAMPLE * baud rate
//   rx           in  asynchronous serial input, idle high
//   rx_data      out received byte (holding register)
//   rx_valid     out holding register full, held until rx_ready
//   rx_ready     in  consumer accepts; handshake = rx_valid & rx_ready
//   frame_err    out stop bit sampled 0 for the held byte
//   overrun_err  out at least one frame lost while rx_valid was high
//   parity_err   out parity mismatch for the held byte
//   busy         out receiver FSM not idle
// -----------------------------------------------------------------------------
module uart_rx_oversampled
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int SAMPLE     = 16,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 sample_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun_err,
  output logic                 parity_err,
  output logic                 busy
);

  localparam int TW = cnt_width(SAMPLE);
  localparam int BW = cnt_width(DATA_BITS);

  if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
    $error("uart_rx_oversampled: DATA_BITS must be 5..8");
  end
  if (SAMPLE < 8 || (SAMPLE % 2) != 0) begin : g_bad_sample
    $error("uart_rx_oversampled: SAMPLE must be even and >= 8");
  end
  if (PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_parity_odd
    $error("uart_rx_oversampled: PARITY_ODD must be 0 or 1");
  end

  logic                 w_rx_s;
  logic                 w_mid_bit;
  logic                 w_handshake;

  rx_state_e            r_state;
  logic [TW-1:0]        r_tick_cnt;
  logic [BW-1:0]        r_bit_cnt;
  logic [DATA_BITS-1:0] r_shreg;
  logic                 r_busy;
  logic                 r_done;      // one-clk pulse after the stop sample
  logic                 r_fe_pend;   // frame error of the frame being handed over

  logic [DATA_BITS-1:0] r_rx_data;
  logic                 r_rx_valid;
  logic                 r_frame_err;
  logic                 r_overrun_err;

  uart_bit_sync #(.RESET_VAL(1'b1)) u_rx_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .i_async (rx),
    .o_sync  (w_rx_s)
  );

  // After the half-bit start check the counter is realigned to 0, so every
  // later wrap at SAMPLE-1 lands in the middle of a bit.
  assign w_mid_bit   = (r_tick_cnt == TW'(SAMPLE - 1));
  assign w_handshake = r_rx_valid & rx_ready;

`ifdef UART_RX_PARITY_EN
  logic r_pe_pend;
  logic r_parity_err;
`endif

  // Receiver FSM; advances only on sample_tick.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_tick_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shreg    <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_fe_pend  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_pe_pend  <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      if (sample_tick) begin
        unique case (r_state)
          IDLE: begin
            if (!w_rx_s) begin
              r_state    <= START;
              r_busy     <= 1'b1;
              r_tick_cnt <= '0;
            end
          end
          START: begin
            if (r_tick_cnt == TW'(SAMPLE / 2 - 1)) begin
              r_tick_cnt <= '0;
              r_bit_cnt  <= '0;
              if (w_rx_s) begin
                // Line back high at mid start bit: treat as a glitch.
                r_state <= IDLE;
                r_busy  <= 1'b0;
              end else begin
                r_state <= DATA;
              end
            end else begin
              r_tick_cnt <= r_tick_cnt + 1'b1;
            end
          end
          DATA: begin
            if (w_mid_bit) begin
              r_tick_cnt <= '0;
              r_shreg    <= {w_rx_s, r_shreg[DATA_BITS-1:1]};
              if (r_bit_cnt == BW'(DATA_BITS - 1)) begin
                r_bit_cnt <= '0;
`ifdef UART_RX_PARITY_EN
                r_state   <= PARITY;
`else
                r_state   <= STOP;
`endif
              end else begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
              end
            end else begin
              r_tick_cnt <= r_tick_cnt + 1'b1;
            end
          end
`ifdef UART_RX_PARITY_EN
          PARITY: begin
            if (w_mid_bit) begin
              r_tick_cnt <= '0;
              r_pe_pend  <= (^{r_shreg, w_rx_s}) ^ 1'(PARITY_ODD);
              r_state    <= STOP;
            end else begin
              r_tick_cnt <= r_tick_cnt + 1'b1;
            end
          end
`endif
          STOP: begin
            if (w_mid_bit) begin
              // Return to IDLE at mid stop bit so a following start edge
              // inside this bit period is still caught.
              r_tick_cnt <= '0;
              r_fe_pend  <= ~w_rx_s;
              r_done     <= 1'b1;
              r_state    <= IDLE;
              r_busy     <= 1'b0;
            end else begin
              r_tick_cnt <= r_tick_cnt + 1'b1;
            end
          end
          default: begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  // Holding register. A frame is accepted when the register is empty or is
  // being emptied in the same clk; otherwise it is dropped and overrun is
  // flagged until the consumer takes the held byte.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rx_data     <= '0;
      r_rx_valid    <= 1'b0;
      r_frame_err   <= 1'b0;
      r_overrun_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_parity_err  <= 1'b0;
`endif
    end else if (r_done) begin
      if (!r_rx_valid || w_handshake) begin
        r_rx_data     <= r_shreg;
        r_rx_valid    <= 1'b1;
        r_frame_err   <= r_fe_pend;
        r_overrun_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
        r_parity_err  <= r_pe_pend;
`endif
      end else begin
        r_overrun_err <= 1'b1;
      end
    end else if (w_handshake) begin
      r_rx_valid    <= 1'b0;
      r_frame_err   <= 1'b0;
      r_overrun_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_parity_err  <= 1'b0;
`endif
    end
  end

  assign rx_data     = r_rx_data;
  assign rx_valid    = r_rx_valid;
  assign frame_err   = r_frame_err;
  assign overrun_err = r_overrun_err;
  assign busy        = r_busy;
`ifdef UART_RX_PARITY_EN
  assign parity_err  = r_parity_err;
`else
  assign parity_err  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_oversampled
// Directed bench for uart_rx_oversampled (DATA_BITS=8, SAMPLE=16, one
// sample_tick every 4 clk, so one bit period = 64 clk). A transaction-level
// model of the holding register is updated when a frame is known to be
// complete and on every handshake; a compare process checks all status
// outputs against it on each falling clk edge, except in the short window
// around the stop-bit sample where the delivery clk is not pinned down.
// Literal expectations pin the model at key points.
// -----------------------------------------------------------------------------
module tb_uart_rx_oversampled;

  localparam int DATA_BITS    = 8;
  localparam int SAMPLE       = 16;
  localparam int CLK_PER_TICK = 4;
  localparam int BIT_CLK      = SAMPLE * CLK_PER_TICK;
  localparam int PARITY_ODD   = 0;

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic                 sample_tick = 1'b0;
  logic                 rx;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 frame_err;
  logic                 overrun_err;
  logic                 parity_err;
  logic                 busy;

  int unsigned          tick_div = 0;

  // Model of the holding register.
  logic                 m_valid;
  logic [DATA_BITS-1:0] m_data;
  logic                 m_fe;
  logic                 m_ov;
  logic                 m_pe;
  logic                 m_settled;

  int n_checks = 0;
  int n_pass   = 0;

  uart_rx_oversampled #(
    .DATA_BITS  (DATA_BITS),
    .SAMPLE     (SAMPLE),
    .PARITY_ODD (PARITY_ODD)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .sample_tick (sample_tick),
    .rx          (rx),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .frame_err   (frame_err),
    .overrun_err (overrun_err),
    .parity_err  (parity_err),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    tick_div    <= (tick_div == CLK_PER_TICK - 1) ? 0 : tick_div + 1;
    sample_tick <= (tick_div == CLK_PER_TICK - 1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (m_settled) begin
      check("rx_valid",    32'(rx_valid),    32'(m_valid));
      check("rx_data",     32'(rx_data),     32'(m_data));
      check("frame_err",   32'(frame_err),   32'(m_fe));
      check("overrun_err", 32'(overrun_err), 32'(m_ov));
      check("parity_err",  32'(parity_err),  32'(m_pe));
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_clear();
    m_valid = 1'b0;
    m_fe    = 1'b0;
    m_ov    = 1'b0;
    m_pe    = 1'b0;
  endtask

  // Frame arrival as seen by a one-entry buffer.
  task automatic model_deliver(input logic [DATA_BITS-1:0] d, input logic fe, input logic pe);
    if (!m_valid) begin
      m_valid = 1'b1;
      m_data  = d;
      m_fe    = fe;
      m_pe    = pe;
      m_ov    = 1'b0;
    end else begin
      m_ov = 1'b1;
    end
  endtask

  function automatic logic good_parity(input logic [DATA_BITS-1:0] d);
    // Parity bit that makes the number of ones even (or odd when PARITY_ODD).
    return 1'(($countones(d) + PARITY_ODD) % 2);
  endfunction

  // Drive one full frame; returns at the end of the stop bit.
  task automatic send_frame(input logic [DATA_BITS-1:0] d, input logic stop_bit,
                            input logic par_bit);
    logic pe;
    pe = 1'b0;
    rx = 1'b0;
    wait_clk(BIT_CLK);
    for (int i = 0; i < DATA_BITS; i++) begin
      rx = d[i];
      wait_clk(BIT_CLK);
    end
`ifdef UART_RX_PARITY_EN
    rx = par_bit;
    pe = 1'(($countones(d) + int'(par_bit) + PARITY_ODD) % 2);
    wait_clk(BIT_CLK);
`endif
    rx = stop_bit;
    // The stop bit is sampled a few clk past its middle; skip comparisons
    // around that point and update the model once delivery has surely happened.
    wait_clk(24);
    m_settled = 1'b0;
    wait_clk(24);
    model_deliver(d, ~stop_bit, pe);
    m_settled = 1'b1;
    wait_clk(BIT_CLK - 48);
    rx = 1'b1;
  endtask

  task automatic handshake();
    @(negedge clk);
    rx_ready = 1'b1;
    @(posedge clk);
    #1;
    if (m_valid) model_clear();
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  initial begin
    reset_n   = 1'b0;
    rx        = 1'b1;
    rx_ready  = 1'b0;
    m_data    = '0;
    m_settled = 1'b0;
    model_clear();

    // Reset state
    wait_clk(5);
    check("reset rx_valid",    32'(rx_valid),    32'd0);
    check("reset rx_data",     32'(rx_data),     32'd0);
    check("reset busy",        32'(busy),        32'd0);
    check("reset frame_err",   32'(frame_err),   32'd0);
    check("reset overrun_err", 32'(overrun_err), 32'd0);
    check("reset parity_err",  32'(parity_err),  32'd0);
    reset_n   = 1'b1;
    m_settled = 1'b1;
    wait_clk(2 * BIT_CLK);

    // 1: clean frame 0xA5, held while rx_ready low, then one-clk handshake
    send_frame(8'hA5, 1'b1, good_parity(8'hA5));
    wait_clk(BIT_CLK);
    check("t1 rx_data",  32'(rx_data),  32'hA5);
    check("t1 rx_valid", 32'(rx_valid), 32'd1);
    check("t1 busy",     32'(busy),     32'd0);
    handshake();
    check("t1 rx_valid after handshake", 32'(rx_valid), 32'd0);

    // 2: start glitch of 4 ticks is rejected
    wait_clk(BIT_CLK);
    rx = 1'b0;
    wait_clk(12);
    check("t2 busy during glitch", 32'(busy), 32'd1);
    wait_clk(4);
    rx = 1'b1;
    wait_clk(32);
    check("t2 busy after glitch", 32'(busy), 32'd0);
    check("t2 rx_valid",          32'(rx_valid), 32'd0);
    wait_clk(BIT_CLK);

    // 3: stop bit 0 -> byte delivered with frame_err
    send_frame(8'h3C, 1'b0, good_parity(8'h3C));
    wait_clk(2 * BIT_CLK);
    check("t3 rx_data",   32'(rx_data),   32'h3C);
    check("t3 frame_err", 32'(frame_err), 32'd1);
    check("t3 rx_valid",  32'(rx_valid),  32'd1);
    handshake();
    wait_clk(BIT_CLK);

    // 4: back-to-back frames with no consumer -> second one overruns
    send_frame(8'h11, 1'b1, good_parity(8'h11));
    send_frame(8'h22, 1'b1, good_parity(8'h22));
    wait_clk(BIT_CLK);
    check("t4 rx_data",     32'(rx_data),     32'h11);
    check("t4 overrun_err", 32'(overrun_err), 32'd1);
    check("t4 frame_err",   32'(frame_err),   32'd0);
    handshake();
    check("t4 rx_valid after handshake",    32'(rx_valid),    32'd0);
    check("t4 overrun_err after handshake", 32'(overrun_err), 32'd0);
    wait_clk(BIT_CLK);

`ifdef UART_RX_PARITY_EN
    // 5: even parity on 0x07 (three ones)
    send_frame(8'h07, 1'b1, 1'b0);
    wait_clk(BIT_CLK);
    check("t5 parity_err bad",  32'(parity_err), 32'd1);
    handshake();
    send_frame(8'h07, 1'b1, 1'b1);
    wait_clk(BIT_CLK);
    check("t5 parity_err good", 32'(parity_err), 32'd0);
    check("t5 rx_data",         32'(rx_data),    32'h07);
    handshake();
    wait_clk(BIT_CLK);
`endif

    // 6: reset mid-DATA of 0xFF while a byte is held, then a clean frame
    send_frame(8'h81, 1'b1, good_parity(8'h81));
    wait_clk(BIT_CLK);
    check("t6 held byte", 32'(rx_data), 32'h81);
    rx = 1'b0;
    wait_clk(BIT_CLK);
    rx = 1'b1;
    wait_clk(3 * BIT_CLK + BIT_CLK / 2);
    check("t6 busy mid-frame", 32'(busy), 32'd1);
    m_settled = 1'b0;
    reset_n   = 1'b0;
    m_data    = '0;
    model_clear();
    wait_clk(3);
    check("t6 reset rx_valid",    32'(rx_valid),    32'd0);
    check("t6 reset rx_data",     32'(rx_data),     32'd0);
    check("t6 reset busy",        32'(busy),        32'd0);
    check("t6 reset overrun_err", 32'(overrun_err), 32'd0);
    m_settled = 1'b1;
    wait_clk(10);
    reset_n = 1'b1;
    wait_clk(2 * BIT_CLK);
    send_frame(8'h5A, 1'b1, good_parity(8'h5A));
    wait_clk(BIT_CLK);
    check("t6 rx_data",     32'(rx_data),     32'h5A);
    check("t6 rx_valid",    32'(rx_valid),    32'd1);
    check("t6 frame_err",   32'(frame_err),   32'd0);
    check("t6 overrun_err", 32'(overrun_err), 32'd0);
    check("t6 parity_err",  32'(parity_err),  32'd0);
    handshake();
    wait_clk(4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
